// File: rtl/wb_uart_dbg_master.sv
// wb_uart_dbg_master: UART-to-Wishbone debug master.
// Host protocol: cmd (0x01 write / 0x02 read), size N, 4 address bytes MSB-first,
// then for writes N data words of 4 bytes MSB-first; reads echo N words MSB-first.
// Optional feature macro: WB_UART_DBG_TIMEOUT_EN (ack-wait timeout, TIMEOUT_CYC cycles).
module wb_uart_dbg_master #(
    parameter int BAUD_DIV    = 434,
    parameter int ADDR_STEP   = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        ser_rx,
    output logic        ser_tx,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy_o,
    output logic        err_o
);

    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 2;
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);

    if (BAUD_DIV < 4 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("wb_uart_dbg_master: BAUD_DIV must be >= 4 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [2:0] {IDLE, SIZE, ADDR, WDATA, WB_WR, WB_RD, RDATA_TX} state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    state_t    state, state_nx;
    rx_state_t rx_st;

    logic          rx_meta, rx_sync, rx_prev;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_data;
    logic          rx_valid, rx_ferr;

    logic          tx_busy, tx_ready, tx_start;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [8:0]    tx_shift;
    logic [7:0]    tx_byte;

    logic [7:0]  n_q;
    logic [31:0] adr_q, wdat_q, rdat_q;
    logic [1:0]  byte_cnt;
    logic        is_read, abort_pend, abort, ack_ev, tmo_hit;

    // Receiver: synchronize ser_rx, qualify the start bit at mid-bit, sample 8 data bits and the stop bit
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_st    <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_meta  <= ser_rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_st)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                    if (rx_prev && !rx_sync) rx_st <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == HALF_M1) begin
                        rx_cnt <= '0;
                        rx_st  <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == FULL_M1) begin
                        rx_cnt  <= '0;
                        rx_data <= {rx_sync, rx_data[7:1]};
                        rx_bit  <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) rx_st <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (rx_cnt == FULL_M1) begin
                        rx_cnt <= '0;
                        rx_st  <= RX_IDLE;
                        if (rx_sync) rx_valid <= 1'b1;
                        else         rx_ferr  <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Transmitter: shift out start bit, 8 data bits LSB first and stop bit, BAUD_DIV cycles each
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ser_tx   <= 1'b1;
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else if (!tx_busy) begin
            if (tx_start) begin
                ser_tx   <= 1'b0;
                tx_shift <= {1'b1, tx_byte};
                tx_busy  <= 1'b1;
                tx_cnt   <= '0;
                tx_bit   <= '0;
            end
        end else if (tx_cnt == FULL_M1) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
                tx_busy <= 1'b0;
                ser_tx  <= 1'b1;
            end else begin
                ser_tx   <= tx_shift[0];
                tx_shift <= {1'b0, tx_shift[8:1]};
                tx_bit   <= tx_bit + 1'b1;
            end
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

    assign tx_ready = !tx_busy;

`ifdef WB_UART_DBG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = wbm_stb_o && !wbm_ack_i && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    // Ack-wait counter: runs while stb is high, cleared whenever the bus cycle ends
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)                      tmo_cnt <= '0;
        else if (wbm_stb_o && !ack_ev)     tmo_cnt <= tmo_cnt + 1'b1;
        else                               tmo_cnt <= '0;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nx;
    end

    // FSM next state; a framing error aborts at once unless a bus cycle is in flight
    always_comb begin
        state_nx = state;
        abort    = abort_pend | rx_ferr;
        ack_ev   = wbm_ack_i | tmo_hit;
        case (state)
            IDLE:     if (rx_valid && (rx_data == 8'h01 || rx_data == 8'h02)) state_nx = SIZE;
            SIZE:     if (rx_valid) state_nx = ADDR;
            ADDR:     if (rx_valid && byte_cnt == 2'd3)
                          state_nx = (n_q == 8'd0) ? IDLE : (is_read ? WB_RD : WDATA);
            WDATA:    if (rx_valid && byte_cnt == 2'd3) state_nx = WB_WR;
            WB_WR:    if (ack_ev) state_nx = (abort || n_q == 8'd1) ? IDLE : WDATA;
            WB_RD:    if (ack_ev) state_nx = abort ? IDLE : RDATA_TX;
            RDATA_TX: if (tx_ready && byte_cnt == 2'd3) state_nx = (n_q == 8'd1) ? IDLE : WB_RD;
            default:  state_nx = IDLE;
        endcase
        if (rx_ferr && state != WB_WR && state != WB_RD) state_nx = IDLE;
    end

    // FSM outputs decoded from the current state
    always_comb begin
        wbm_cyc_o = (state == WB_WR) || (state == WB_RD);
        wbm_stb_o = wbm_cyc_o;
        wbm_we_o  = (state == WB_WR);
        wbm_sel_o = wbm_cyc_o ? 4'hF : 4'h0;
        wbm_adr_o = adr_q;
        wbm_dat_o = wdat_q;
        busy_o    = (state != IDLE);
        tx_start  = (state == RDATA_TX) && tx_ready;
        case (byte_cnt)
            2'd0:    tx_byte = rdat_q[31:24];
            2'd1:    tx_byte = rdat_q[23:16];
            2'd2:    tx_byte = rdat_q[15:8];
            default: tx_byte = rdat_q[7:0];
        endcase
    end

    // Datapath: collect size/address/data bytes, step the address and count words
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            n_q        <= '0;
            adr_q      <= '0;
            wdat_q     <= '0;
            rdat_q     <= '0;
            byte_cnt   <= '0;
            is_read    <= 1'b0;
            abort_pend <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            err_o <= rx_ferr | tmo_hit;
            case (state)
                IDLE: begin
                    byte_cnt   <= '0;
                    abort_pend <= 1'b0;
                    if (rx_valid) is_read <= (rx_data == 8'h02);
                end
                SIZE: if (rx_valid) n_q <= rx_data;
                ADDR: if (rx_valid) begin
                    adr_q    <= {adr_q[23:0], rx_data};
                    byte_cnt <= byte_cnt + 1'b1;
                end
                WDATA: if (rx_valid) begin
                    wdat_q   <= {wdat_q[23:0], rx_data};
                    byte_cnt <= byte_cnt + 1'b1;
                end
                WB_WR: begin
                    if (rx_ferr) abort_pend <= 1'b1;
                    if (ack_ev) begin
                        adr_q <= adr_q + 32'(ADDR_STEP);
                        n_q   <= n_q - 1'b1;
                    end
                end
                WB_RD: begin
                    if (rx_ferr) abort_pend <= 1'b1;
                    if (wbm_ack_i)    rdat_q <= wbm_dat_i;
                    else if (tmo_hit) rdat_q <= 32'hFFFF_FFFF;
                end
                RDATA_TX: if (tx_ready) begin
                    byte_cnt <= byte_cnt + 1'b1;
                    if (byte_cnt == 2'd3) begin
                        adr_q <= adr_q + 32'(ADDR_STEP);
                        n_q   <= n_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/wb_uart_dbg_master.md
Name: wb_uart_dbg_master

Overview:
- Synthesizable UART-to-Wishbone debug master.
- Lets a host (or the sim UART host model) read and write the mgmt SoC bus over a serial line, with multi-word bursts, auto-incrementing addresses and configurable baud.
- Sits beside the mgmt core as a second Wishbone master, arbitrated upstream.
- Byte protocol is the team's existing debug protocol: cmd, size, 4 address bytes MSB-first, data bytes MSB-first.

Parameters:
- BAUD_DIV, 434: wb_clk_i cycles per UART bit (50 MHz / 115200). Minimum 4.
- ADDR_STEP, 4: byte increment applied to address after each burst word.
- TIMEOUT_CYC, 1024: ack-wait limit in cycles; used only with the optional feature.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  asynchronous active-high reset
- ser_rx  in  1  UART receive, idle high, asynchronous to clock
- ser_tx  out  1  UART transmit, idle high
- wbm_cyc_o  out  1  bus cycle
- wbm_stb_o  out  1  strobe
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  4  byte selects, always 4'hF when stb high
- wbm_adr_o  out  32  byte address
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  acknowledge
- busy_o  out  1  high whenever FSM not in IDLE
- err_o  out  1  one-cycle pulse on framing error (or timeout, see below)

Behaviour:
- Clock: one clock, wb_clk_i. Reset: wb_rst_i, asynchronous, active-high.
- Reset values: ser_tx=1; cyc/stb/we=0; sel=0; adr=0; dat_o=0; busy_o=0; err_o=0; FSM=IDLE; RX/TX bit counters=0.
- RX path:
  - ser_rx passes through a 2-flop synchronizer.
  - Falling edge starts a frame. The start bit is re-checked at BAUD_DIV/2; if high, the frame is a glitch and is dropped.
  - Data bits are sampled every BAUD_DIV cycles thereafter, LSB first.
  - If the stop bit samples 0: framing error, err_o pulses, byte is discarded, FSM returns to IDLE.
  - rx_valid is a one-cycle strobe per good byte.
- TX path: start bit, 8 data bits LSB first, 1 stop bit, each BAUD_DIV cycles. tx_ready is high only when TX is idle.
- FSM states: IDLE, SIZE, ADDR, WDATA, WB_WR, WB_RD, RDATA_TX.
  - IDLE: byte 0x01 -> SIZE (write); 0x02 -> SIZE (read); any other byte is ignored, stay in IDLE.
  - SIZE: latch N (8 bits) -> ADDR.
  - ADDR: shift in 4 bytes MSB-first. After byte 4: if N==0, go to IDLE (no bus access); else go to WDATA (write) or WB_RD (read).
  - WDATA: shift in 4 bytes MSB-first -> WB_WR.
  - WB_WR: assert cyc/stb/we with adr/dat until ack. On ack, drop cyc/stb/we in the same edge, adr += ADDR_STEP, N -= 1. Then N>0 -> WDATA; else -> IDLE.
  - WB_RD: assert cyc/stb (we=0) until ack. Capture wbm_dat_i on ack -> RDATA_TX.
  - RDATA_TX: send 4 bytes MSB-first, each launched when tx_ready. Then adr += ADDR_STEP, N -= 1; N>0 -> WB_RD, else -> IDLE.
- No write response byte is sent.
- Address arithmetic is 32-bit and wraps modulo 2^32.
- cyc and stb always move together; one word per bus cycle.
- Ack is accepted only while stb is high.
- Bytes received while in WB_WR, WB_RD or RDATA_TX are dropped; the protocol is strictly half-duplex.
- A framing error in any state aborts to IDLE with cyc/stb deasserted, except when a bus cycle is in flight: that cycle completes first.
- Reset mid-transfer: everything returns immediately to reset values, and ser_tx is forced high even mid-byte.

Optional Feature:
- Macro: WB_UART_DBG_TIMEOUT_EN.
- Defined: a counter runs while stb is high.
  - When it reaches TIMEOUT_CYC without ack, cyc/stb drop and err_o pulses.
  - Write: the word is skipped and the burst continues.
  - Read: 32'hFFFFFFFF is returned in place of data.
- Undefined: waits for ack indefinitely; no counter logic is present.

Test Plan:
- Bytes 01 01 00 00 01 10 77 55 55 AB -> one write: adr=0x00000110, dat=0x775555AB, sel=F. Then 02 01 00 00 01 10 with slave returning 0x775555AB -> ser_tx bytes 77 55 55 AB.
- Burst write 01 03 addr 0x00000200, words 0x11111111, 0x22222222, 0x33333333 -> writes at 0x200, 0x204, 0x208. Read burst 02 03 addr 0x200 -> 12 bytes echoed in order.
- Size zero: 02 00 00 00 00 00 -> no cyc asserted, no TX bytes, busy_o low after the last byte. Unknown cmd 07 then a valid read -> read completes normally.
- Framing error: stop bit forced 0 on the 3rd address byte -> err_o pulses once, FSM returns to IDLE, and the following valid command works.
- Assert wb_rst_i during RDATA_TX byte 2 -> ser_tx=1 and cyc=0 immediately; post-reset read at 0x110 succeeds.
- With WB_UART_DBG_TIMEOUT_EN and TIMEOUT_CYC=16, slave never acks a read -> stb drops after 16 cycles, err_o pulses, TX bytes FF FF FF FF.
